// File: rtl/mips_defs.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// FSM state encoding and default latencies.
package mips_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } mdOp_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdState_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, req, input busy, HI, LO);
  modport slave  (input start, op, A, B, req, output busy, HI, LO);
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: {HI,LO} result for the selected op
// plus a divide-by-zero flag.
module md_calc
  import mips_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] result,
  output logic        divZero
);

  logic signed [63:0] aExt, bExt, sProd;
  logic [63:0] uProd;
  logic        negA, negB;
  logic [31:0] aMag, bMag, sDivisor, uDivisor;
  logic [31:0] qMag, rMag, sQuo, sRem, uQuo, uRem;

  always_comb begin
    divZero = (B == 32'd0);
    negA    = A[31];
    negB    = B[31];

    aExt  = $signed({{32{A[31]}}, A});
    bExt  = $signed({{32{B[31]}}, B});
    sProd = aExt * bExt;
    uProd = {32'd0, A} * {32'd0, B};

    // Signed divide done on magnitudes so 0x80000000 / -1 needs no special case.
    aMag     = negA ? (~A + 32'd1) : A;
    bMag     = negB ? (~B + 32'd1) : B;
    sDivisor = divZero ? 32'd1 : bMag;
    uDivisor = divZero ? 32'd1 : B;
    qMag     = aMag / sDivisor;
    rMag     = aMag % sDivisor;
    sQuo     = (negA ^ negB) ? (~qMag + 32'd1) : qMag;
    sRem     = negA ? (~rMag + 32'd1) : rMag;
    uQuo     = A / uDivisor;
    uRem     = A % uDivisor;

    case (op)
      MD_MULT:  result = sProd;
      MD_MULTU: result = uProd;
      MD_DIV:   result = {sRem, sQuo};
      MD_DIVU:  result = {uRem, uQuo};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div sequencing and the
// architectural HI/LO registers.
module mult_div_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdState_e         state;
  logic [CNT_W-1:0] count;
  logic [31:0]      tempHi, tempLo, hiReg, loReg;
  logic             skipWrite, busyReg;
  logic [63:0]      calcResult;
  logic             calcDivZero;
  logic             accept;

  md_calc uCalc (
    .op      (bus.op),
    .A       (bus.A),
    .B       (bus.B),
    .result  (calcResult),
    .divZero (calcDivZero)
  );

  assign accept   = bus.start && !bus.req && (state == IDLE);
  assign bus.busy = busyReg;
  assign bus.HI   = hiReg;
  assign bus.LO   = loReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      tempHi    <= '0;
      tempLo    <= '0;
      skipWrite <= 1'b0;
      busyReg   <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.op)
              MD_MULT, MD_MULTU: begin
                tempHi    <= calcResult[63:32];
                tempLo    <= calcResult[31:0];
                skipWrite <= 1'b0;
                count     <= CNT_W'(MULT_CYCLES);
                busyReg   <= 1'b1;
                state     <= RUN;
              end
              MD_DIV, MD_DIVU: begin
                // Divide by zero still occupies the full latency but leaves HI/LO alone.
                tempHi    <= calcResult[63:32];
                tempLo    <= calcResult[31:0];
                skipWrite <= calcDivZero;
                count     <= CNT_W'(DIV_CYCLES);
                busyReg   <= 1'b1;
                state     <= RUN;
              end
              MD_MTHI: hiReg <= bus.A;
              MD_MTLO: loReg <= bus.A;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            if (!skipWrite) begin
              hiReg <= tempHi;
              loReg <= tempLo;
            end
            busyReg <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, busy lengths,
// req cancellation, operand sampling and asynchronous reset.
module tb_mult_div_unit;
  import mips_defs::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one start for a single cycle, then scramble the operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    step();
    bus.start = 1'b0;
    bus.op    = 3'b111;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h1234_5678;
  endtask

  // Count remaining busy cycles, bounded so a stuck busy cannot hang the run.
  task automatic waitBusy(input string tag, input int expCycles);
    int n = 0;
    while (bus.busy && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(expCycles));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.req   = 1'b0;
    bus.op    = 3'b111;
    bus.A     = '0;
    bus.B     = '0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("reset_hi", bus.HI, 32'h0);
    chk("reset_lo", bus.LO, 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'd0);

    // mult -2 * 3
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_rise", 32'(bus.busy), 32'd1);
    waitBusy("mult_busy_len", 5);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    waitBusy("multu_busy_len", 5);
    chk("multu_hi", bus.HI, 32'h0000_0002);
    chk("multu_lo", bus.LO, 32'hFFFF_FFFA);

    // div -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    waitBusy("div_busy_len", 10);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);

    // mthi/mtlo then divu by zero
    issue(MD_MTHI, 32'h11, 32'd0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_hi", bus.HI, 32'h11);
    issue(MD_MTLO, 32'h22, 32'd0);
    chk("mtlo_lo", bus.LO, 32'h22);
    issue(MD_DIVU, 32'd7, 32'd0);
    chk("divz_busy_rise", 32'(bus.busy), 32'd1);
    waitBusy("divz_busy_len", 10);
    chk("divz_hi", bus.HI, 32'h11);
    chk("divz_lo", bus.LO, 32'h22);

    // divu 100 / 7
    issue(MD_DIVU, 32'd100, 32'd7);
    waitBusy("divu_busy_len", 10);
    chk("divu_lo", bus.LO, 32'd14);
    chk("divu_hi", bus.HI, 32'd2);

    // overflow case
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitBusy("ovf_busy_len", 10);
    chk("ovf_lo", bus.LO, 32'h8000_0000);
    chk("ovf_hi", bus.HI, 32'h0);

    // req cancels a same-cycle start
    bus.req = 1'b1;
    issue(MD_MTLO, 32'h55, 32'd0);
    chk("req_mtlo_lo", bus.LO, 32'h8000_0000);
    chk("req_mtlo_busy", 32'(bus.busy), 32'd0);
    issue(MD_MULT, 32'd9, 32'd9);
    bus.req = 1'b0;
    chk("req_mult_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    chk("req_mult_busy_later", 32'(bus.busy), 32'd0);
    chk("req_mult_lo", bus.LO, 32'h8000_0000);
    chk("req_mult_hi", bus.HI, 32'h0);

    // operand sampling, start while busy, req while busy
    issue(MD_MULT, 32'h1000, 32'd7);
    bus.start = 1'b1;
    bus.op    = MD_DIVU;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 32'd1;
    step();
    bus.start = 1'b0;
    bus.req   = 1'b1;
    step();
    bus.req   = 1'b0;
    waitBusy("sample_busy_len", 3);
    chk("sample_hi", bus.HI, 32'h0);
    chk("sample_lo", bus.LO, 32'h7000);
    step();
    step();
    chk("sample_no_restart", 32'(bus.busy), 32'd0);

    // async reset mid-run, checked before the next clock edge
    issue(MD_DIV, 32'd100, 32'd3);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("areset_busy", 32'(bus.busy), 32'd0);
    chk("areset_hi", bus.HI, 32'h0);
    chk("areset_lo", bus.LO, 32'h0);
    step();
    reset = 1'b1;
    step();
    step();
    chk("areset_after_busy", 32'(bus.busy), 32'd0);
    chk("areset_after_lo", bus.LO, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
